alu_nbit_pipe: RTL and testbench
================================

ALU_NBIT_PIPE -- requirements
Module: alu_nbit_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a  input  WIDTH  operand A, two's complement.
REQ-007 b  input  WIDTH  operand B, two's complement.
REQ-008 ctrl  input  4  {Ainvert, Binvert, op[1:0]} operation select.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  downstream consumes result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 c_out  output  1  carry out of MSB adder.
REQ-014 overflow  output  1  signed overflow.
REQ-015 illegal  output  1  ctrl code not in legal set.

Function
REQ-016 Legal ctrl codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
REQ-017 Datapath SHALL be A' = Ainvert ? ~a : a, B' = Binvert ? ~b : b; op 00 = A'&B', 01 = A'|B', 10 = A'+B'+Binvert, 11 = SLT.
REQ-018 SLT SHALL form A'+B'+1 (a-b), set = sum[WIDTH-1] XOR signed overflow, result = {WIDTH-1 zeros, set}.
REQ-019 overflow SHALL be signed overflow of the adder for ADD/SUB only, 0 for all other codes including SLT.
REQ-020 c_out SHALL be the adder carry out of bit WIDTH-1 for ADD/SUB/SLT, 0 otherwise.
REQ-021 Illegal ctrl SHALL produce result 0, zero 1, c_out 0, overflow 0, illegal 1; legal codes give illegal 0.
REQ-022 Pipeline SHALL have two register stages: S1 holds a, b, ctrl; S2 holds result and flags; each stage has a valid bit.
REQ-023 Input transfer SHALL occur on a rising edge with in_valid & in_ready; output transfer with out_valid & out_ready.
REQ-024 Latency: operation accepted at edge E0 SHALL appear on outputs with out_valid=1 immediately after edge E0+1 when S2 is free.
REQ-025 S2 SHALL load from S1 when S1 valid and (S2 empty or out_ready); else S2 holds all outputs stable.
REQ-026 in_ready SHALL be combinational: !S1_valid OR S1 advancing to S2 this cycle.
REQ-027 With out_ready held 1, throughput SHALL be one operation per cycle with no bubbles.
REQ-028 Under backpressure at most two operations SHALL be held; no loss, no duplication, order preserved.
REQ-029 Outputs SHALL not change while out_valid=1 and out_ready=0.
REQ-030 a, b, ctrl SHALL be ignored when no input transfer occurs.

Reset
REQ-031 rst_n low SHALL immediately clear both valid bits, drive in_ready 1 after release, out_valid 0, result 0, zero 0, c_out 0, overflow 0, illegal 0.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; first post-reset transfer behaves as from idle.

Verification
REQ-033 ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, overflow 1, c_out 0, zero 0, out_valid one edge after S1 load.
REQ-034 SUB a=5 b=5 -> result 0, zero 1, c_out 1, overflow 0; SUB a=0x80000000 b=1 -> 0x7FFFFFFF, overflow 1.
REQ-035 SLT a=0xFFFFFFFF b=1 -> result 1; SLT a=0x7FFFFFFF b=0x80000000 -> result 0, overflow 0.
REQ-036 a=0xF0F0F0F0 b=0xFF00FF00: AND 0xF000F000, OR 0xFFF0FFF0, NOR 0x000F000F, NAND 0x0FFF0FFF, illegal 0.
REQ-037 Stream of 4 ops with out_ready low 3 cycles -> two held, in_ready 0, outputs stable; on release all 4 delivered in order exactly once.
REQ-038 ctrl=0011 -> result 0, zero 1, illegal 1; rst_n pulsed low with two ops in flight -> out_valid 0 at once, neither op ever delivered.

Source files
------------

// File: rtl/alu_nbit_pipe.sv
// Two-stage pipelined N-bit ALU with valid/ready handshakes on both sides.
// S1 registers the operands and ctrl; S2 registers the result and flags.
module alu_nbit_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             overflow,
  output logic             illegal
);

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  // ALU datapath on S1 contents
  logic [WIDTH-1:0] a_op, b_op;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_ill;

  logic s2_load;
  logic in_fire;
  logic out_fire;

  always_comb begin
    a_op    = ctrl_q[3] ? ~a_q : a_q;
    b_op    = ctrl_q[2] ? ~b_q : b_q;
    sum     = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, ctrl_q[2]};
    // Signed overflow: operands agree in sign but the sum does not.
    add_ovf = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);

    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (ctrl_q)
      4'b0000, 4'b1100: alu_res = a_op & b_op;
      4'b0001, 4'b1101: alu_res = a_op | b_op;
      4'b0010, 4'b0110: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = add_ovf;
      end
      4'b0111: begin
        alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        alu_cout = sum[WIDTH];
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      ctrl_d     = ctrl;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      c_out_d    = alu_cout;
      overflow_d = alu_ovf;
      illegal_d  = alu_ill;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_nbit_pipe.sv
// Scoreboard bench for alu_nbit_pipe: driver pushes model results on accept,
// monitor pops and compares on every output transfer.
module tb_alu_nbit_pipe;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         cout;
    logic         ovf;
    logic         ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, c_out, overflow, illegal;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  alu_nbit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .c_out     (c_out),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [3:0] cv);
    exp_t e;
    longint sa, sbv, s;
    longint unsigned ua, ub;
    longint smax, smin;
    sa   = longint'($signed(av));
    sbv  = longint'($signed(bv));
    ua   = longint'(av);
    ub   = longint'(bv);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    e = '0;
    case (cv)
      4'b0000: e.res = av & bv;
      4'b0001: e.res = av | bv;
      4'b1100: e.res = ~(av | bv);
      4'b1101: e.res = ~(av & bv);
      4'b0010: begin
        e.res  = av + bv;
        e.cout = ((ua + ub) >> W) != 0;
        s      = sa + sbv;
        e.ovf  = (s > smax) || (s < smin);
      end
      4'b0110: begin
        e.res  = av - bv;
        e.cout = (ua >= ub);
        s      = sa - sbv;
        e.ovf  = (s > smax) || (s < smin);
      end
      4'b0111: begin
        e.res  = (sa < sbv) ? W'(1) : W'(0);
        e.cout = (ua >= ub);
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // One clock of stimulus; called and returns at posedge+1.
  task automatic cycle(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [3:0] cv, input logic ordy, output logic acc);
    in_valid  = iv;
    a         = av;
    b         = bv;
    ctrl      = cv;
    out_ready = ordy;
    @(negedge clk);
    acc = iv && in_ready;
    @(posedge clk);
    if (acc && rst_n) sb.push_back(model(av, bv, cv));
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] cv,
                      input logic ordy);
    logic acc;
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cycle(1'b1, av, bv, cv, ordy, acc);
      n++;
    end
    if (!acc) begin
      failures++;
      $display("FAIL send_accept got=timeout exp=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      cycle(1'b0, '0, '0, 4'b0000, 1'b1, acc);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: in_ready from occupancy, stability under stall, scoreboard pop.
  logic held = 1'b0;
  logic [W+3:0] last_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
      if (held) check("stall_stable", 64'({out_valid, result, zero, c_out, overflow, illegal}),
                      64'({1'b1, last_out}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got=%0h exp=none", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", 64'({result, zero, c_out, overflow, illegal}), 64'(e));
        end
      end
      held     = out_valid && !out_ready;
      last_out = {result, zero, c_out, overflow, illegal};
    end
  end

  logic [3:0] legal_codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};

  initial begin
    logic acc;
    logic [3:0] cv;
    logic [W-1:0] av, bv;

    #22;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outs", 64'({out_valid, result, zero, c_out, overflow, illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency from idle: out_valid just after the edge following acceptance.
    cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b1, acc);
    in_valid = 1'b0;
    check("lat_pre", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("add_ovf_res", 64'({result, overflow, c_out, zero}), 64'({32'h8000_0000, 3'b100}));
    drain();

    send(32'd5, 32'd5, 4'b0110, 1'b1);
    send(32'h8000_0000, 32'd1, 4'b0110, 1'b1);
    send(32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b1);
    send(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 1'b1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 1'b1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1100, 1'b1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1101, 1'b1);
    send(32'h1234_5678, 32'h9ABC_DEF0, 4'b0011, 1'b1);
    drain();

    // Backpressure: two held, third blocked for three cycles.
    send(32'd10, 32'd3, 4'b0010, 1'b0);
    send(32'd10, 32'd3, 4'b0110, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'd7, 32'd9, 4'b0111, 1'b0, acc);
      check("bp_blocked", 64'(acc), 64'd0);
    end
    check("bp_full_ready", 64'(in_ready), 64'd0);
    send(32'd7, 32'd9, 4'b0111, 1'b1);
    send(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1101, 1'b1);
    drain();

    // Randomized mix with random backpressure.
    for (int i = 0; i < 600; i++) begin
      cv = ($urandom_range(0, 3) != 0) ? legal_codes[$urandom_range(0, 6)] : 4'($urandom);
      av = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      bv = ($urandom_range(0, 7) == 0) ? av : $urandom;
      cycle(1'($urandom_range(0, 3) != 0), av, bv, cv, 1'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    // Reset with two operations in flight.
    send(32'd1, 32'd2, 4'b0010, 1'b0);
    send(32'd3, 32'd4, 4'b0010, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 64'({out_valid, result, zero, c_out, overflow, illegal}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 4'b0000, 1'b1, acc);
      check("midrst_no_out", 64'(out_valid), 64'd0);
    end
    send(32'd100, 32'd1, 4'b0110, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
